// File: rtl/regfile.sv
// General-purpose register file with HI/LO pair for the St.PU pipeline.
// Combinational reads with same-cycle WB bypass; writes commit on the rising edge.
module regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [15:0]       wr_count
);

    logic [DATA_W-1:0] regs [1:REG_NUM-1];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              wr_ok;

    // r0 is hardwired to zero, so writes to it are neither stored nor counted
    assign wr_ok = we && (waddr != 5'd0) && (int'(waddr) < REG_NUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            hi       <= '0;
            lo       <= '0;
            wr_count <= '0;
        end else begin
            if (wr_ok) begin
                regs[waddr] <= wdata;
                wr_count    <= wr_count + 16'd1;
            end
            if (hilo_we) begin
                hi <= hi_i;
                lo <= lo_i;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic       re,
        input logic [4:0] raddr
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (rst || !re || raddr == 5'd0 || int'(raddr) >= REG_NUM) begin
            r = '0;
        end else if (wr_ok && waddr == raddr) begin
            r = wdata;
        end else begin
            r = regs[raddr];
        end
        return r;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule
